// File: rtl/eth_fifo_pkg.sv
// Shared definitions for the Ethernet MAC FIFO write/read side blocks:
// arbiter state encoding and FIFO word field helpers.
package eth_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } arb_state_e;

    function automatic int eop_bit(input int data_width);
        return data_width - 32'sd1;
    endfunction

    function automatic int sop_bit(input int data_width);
        return data_width - 32'sd2;
    endfunction

    // One spare code above the limit so an over-length frame stays distinguishable
    function automatic int word_cnt_width(input int max_frame_words);
        return $clog2(max_frame_words + 32'sd2);
    endfunction

endpackage

// File: rtl/eth_rr_pick2.sv
// Combinational two-way round-robin chooser: on a tie the requester that
// did not go last wins. Output is one-hot, or zero when nobody asks.
module eth_rr_pick2 (
    input  logic [1:0] cand,
    input  logic       last,
    output logic [1:0] winner
);

    // Tie-break against the most recent owner
    always_comb begin
        winner = 2'b00;
        case (cand)
            2'b01:   winner = 2'b01;
            2'b10:   winner = 2'b10;
            2'b11:   winner = last ? 2'b01 : 2'b10;
            default: winner = 2'b00;
        endcase
    end

endmodule

// File: rtl/eth_fifo_wr_arb.sv
// Frame-granular round-robin arbiter sharing the async MAC FIFO write port
// between two frame sources; flags protocol, length and overflow errors.
module eth_fifo_wr_arb
    import eth_fifo_pkg::*;
#(
    parameter int DATA_WIDTH      = 36,
    parameter int MAX_FRAME_WORDS = 400,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                  wr_clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-3:0] req0_data,
    input  logic                  req0_sop,
    input  logic                  req0_eop,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-3:0] req1_data,
    input  logic                  req1_sop,
    input  logic                  req1_eop,
    output logic                  req1_ready,
    output logic [DATA_WIDTH-1:0] fifo_din,
    output logic                  fifo_wr_en,
    input  logic                  fifo_full,
    input  logic                  fifo_overflow,
    output logic [1:0]            grant,
    output logic [CNT_WIDTH-1:0]  frame_cnt0,
    output logic [CNT_WIDTH-1:0]  frame_cnt1,
    output logic                  proto_err,
    output logic                  len_err,
    output logic                  ovf_err
);

    localparam int PW       = DATA_WIDTH - 2;
    localparam int WCW      = word_cnt_width(MAX_FRAME_WORDS);
    localparam int EOP_IDX  = eop_bit(DATA_WIDTH);
    localparam int SOP_IDX  = sop_bit(DATA_WIDTH);
    localparam logic [WCW-1:0]       WCNT_ZERO = {WCW{1'b0}};
    localparam logic [WCW-1:0]       WCNT_ONE  = {{(WCW-1){1'b0}}, 1'b1};
    localparam logic [WCW-1:0]       WCNT_LIM  = WCW'(MAX_FRAME_WORDS);
    localparam logic [WCW-1:0]       WCNT_SAT  = WCW'(MAX_FRAME_WORDS + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    arb_state_e           state_r;
    arb_state_e           state_nxt_s;
    logic                 last_r;
    logic                 last_nxt_s;
    logic [1:0]           grant_r;
    logic [1:0]           grant_nxt_s;
    logic [WCW-1:0]       word_cnt_r;
    logic [WCW-1:0]       word_cnt_nxt_s;
    logic [CNT_WIDTH-1:0] frame_cnt0_r;
    logic [CNT_WIDTH-1:0] frame_cnt1_r;
    logic                 proto_err_r;
    logic                 len_err_r;
    logic                 ovf_err_r;

    logic [1:0]           cand_s;
    logic [1:0]           winner_s;
    logic                 sel_is1_s;
    logic                 sel_valid_s;
    logic                 sel_sop_s;
    logic                 sel_eop_s;
    logic [PW-1:0]        sel_data_s;
    logic                 accept_s;
    logic                 frame_done0_s;
    logic                 frame_done1_s;
    logic                 set_proto_s;
    logic                 set_len_s;

    assign cand_s = {req1_valid & req1_sop, req0_valid & req0_sop};

    eth_rr_pick2 u_pick (
        .cand   (cand_s),
        .last   (last_r),
        .winner (winner_s)
    );

    // Route the current owner's word onto the shared datapath
    always_comb begin
        sel_is1_s = (state_r == BUSY1);
        if (sel_is1_s) begin
            sel_valid_s = req1_valid;
            sel_sop_s   = req1_sop;
            sel_eop_s   = req1_eop;
            sel_data_s  = req1_data;
        end else begin
            sel_valid_s = req0_valid;
            sel_sop_s   = req0_sop;
            sel_eop_s   = req0_eop;
            sel_data_s  = req0_data;
        end
    end

    // Next-state, handshake and FIFO write decode
    always_comb begin
        state_nxt_s    = state_r;
        last_nxt_s     = last_r;
        word_cnt_nxt_s = word_cnt_r;
        req0_ready     = 1'b0;
        req1_ready     = 1'b0;
        fifo_wr_en     = 1'b0;
        fifo_din       = {DATA_WIDTH{1'b0}};
        accept_s       = 1'b0;
        frame_done0_s  = 1'b0;
        frame_done1_s  = 1'b0;
        set_proto_s    = 1'b0;
        set_len_s      = 1'b0;
        case (state_r)
            IDLE: begin
                // Stray mid-frame words are swallowed; sop words wait for arbitration
                req0_ready  = req0_valid & ~req0_sop;
                req1_ready  = req1_valid & ~req1_sop;
                set_proto_s = req0_ready | req1_ready;
                if (winner_s[0]) begin
                    state_nxt_s = BUSY0;
                end else if (winner_s[1]) begin
                    state_nxt_s = BUSY1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY0, BUSY1: begin
                if (sel_is1_s) begin
                    req1_ready = ~fifo_full;
                end else begin
                    req0_ready = ~fifo_full;
                end
                accept_s = sel_valid_s & ~fifo_full;
                if (accept_s) begin
                    fifo_wr_en                = 1'b1;
                    fifo_din[EOP_IDX]         = sel_eop_s;
                    fifo_din[SOP_IDX]         = sel_sop_s;
                    fifo_din[PW-1:0]          = sel_data_s;
                    set_len_s                 = (word_cnt_r >= WCNT_LIM);
                    set_proto_s               = sel_sop_s & (word_cnt_r != WCNT_ZERO);
                    if (sel_eop_s) begin
                        state_nxt_s    = IDLE;
                        last_nxt_s     = sel_is1_s;
                        word_cnt_nxt_s = WCNT_ZERO;
                        frame_done0_s  = ~sel_is1_s;
                        frame_done1_s  = sel_is1_s;
                    end else if (word_cnt_r == WCNT_SAT) begin
                        word_cnt_nxt_s = WCNT_SAT;
                    end else begin
                        word_cnt_nxt_s = word_cnt_r + WCNT_ONE;
                    end
                end else begin
                    word_cnt_nxt_s = word_cnt_r;
                end
            end
            default: begin
                state_nxt_s    = IDLE;
                word_cnt_nxt_s = WCNT_ZERO;
            end
        endcase
    end

    // One-hot grant follows the next owner so it can be registered
    always_comb begin
        case (state_nxt_s)
            BUSY0:   grant_nxt_s = 2'b01;
            BUSY1:   grant_nxt_s = 2'b10;
            default: grant_nxt_s = 2'b00;
        endcase
    end

    // Arbitration state, round-robin history and in-frame word count
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            last_r     <= 1'b1;
            grant_r    <= 2'b00;
            word_cnt_r <= WCNT_ZERO;
        end else begin
            state_r    <= state_nxt_s;
            last_r     <= last_nxt_s;
            grant_r    <= grant_nxt_s;
            word_cnt_r <= word_cnt_nxt_s;
        end
    end

    // Completed-frame counters, wrapping
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            frame_cnt0_r <= {CNT_WIDTH{1'b0}};
            frame_cnt1_r <= {CNT_WIDTH{1'b0}};
        end else begin
            if (frame_done0_s) begin
                frame_cnt0_r <= frame_cnt0_r + CNT_ONE;
            end
            if (frame_done1_s) begin
                frame_cnt1_r <= frame_cnt1_r + CNT_ONE;
            end
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            proto_err_r <= 1'b0;
            len_err_r   <= 1'b0;
            ovf_err_r   <= 1'b0;
        end else begin
            proto_err_r <= proto_err_r | set_proto_s;
            len_err_r   <= len_err_r | set_len_s;
            ovf_err_r   <= ovf_err_r | fifo_overflow;
        end
    end

    assign grant      = grant_r;
    assign frame_cnt0 = frame_cnt0_r;
    assign frame_cnt1 = frame_cnt1_r;
    assign proto_err  = proto_err_r;
    assign len_err    = len_err_r;
    assign ovf_err    = ovf_err_r;

endmodule

// File: tb/tb_eth_fifo_wr_arb.sv
// Directed bench for eth_fifo_wr_arb: queue-fed requesters, per-cycle
// snapshots at the falling edge, hand-computed expectations per scenario.
module tb_eth_fifo_wr_arb;

    localparam int DW   = 36;
    localparam int PW   = DW - 2;
    localparam int MAXW = 4;
    localparam int CW   = 16;

    logic          wr_clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0, req0_sop = 1'b0, req0_eop = 1'b0, req0_ready;
    logic          req1_valid = 1'b0, req1_sop = 1'b0, req1_eop = 1'b0, req1_ready;
    logic [PW-1:0] req0_data = '0, req1_data = '0;
    logic [DW-1:0] fifo_din;
    logic          fifo_wr_en;
    logic          fifo_full = 1'b0, fifo_overflow = 1'b0;
    logic [1:0]    grant;
    logic [CW-1:0] frame_cnt0, frame_cnt1;
    logic          proto_err, len_err, ovf_err;

    always #5 wr_clk = ~wr_clk;

    eth_fifo_wr_arb #(.DATA_WIDTH(DW), .MAX_FRAME_WORDS(MAXW), .CNT_WIDTH(CW)) dut (
        .wr_clk(wr_clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_sop(req0_sop),
        .req0_eop(req0_eop), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_sop(req1_sop),
        .req1_eop(req1_eop), .req1_ready(req1_ready),
        .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
        .fifo_overflow(fifo_overflow), .grant(grant),
        .frame_cnt0(frame_cnt0), .frame_cnt1(frame_cnt1),
        .proto_err(proto_err), .len_err(len_err), .ovf_err(ovf_err)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q0[$], q1[$], wq[$];
    logic [1:0]    s_grant;
    logic          s_wr_en, s_rdy0, s_rdy1;
    logic [DW-1:0] s_din;

    function automatic logic [DW-1:0] mk(input logic eop, input logic sop, input logic [PW-1:0] d);
        return {eop, sop, d};
    endfunction

    // One clock: present queue heads, snapshot at negedge, pop accepted words
    task automatic cycle();
        logic acc0, acc1;
        if (q0.size() > 0) begin
            req0_valid = 1'b1;
            {req0_eop, req0_sop, req0_data} = q0[0];
        end else begin
            req0_valid = 1'b0; req0_eop = 1'b0; req0_sop = 1'b0; req0_data = '0;
        end
        if (q1.size() > 0) begin
            req1_valid = 1'b1;
            {req1_eop, req1_sop, req1_data} = q1[0];
        end else begin
            req1_valid = 1'b0; req1_eop = 1'b0; req1_sop = 1'b0; req1_data = '0;
        end
        @(negedge wr_clk);
        s_grant = grant; s_wr_en = fifo_wr_en; s_din = fifo_din;
        s_rdy0 = req0_ready; s_rdy1 = req1_ready;
        acc0 = req0_valid & req0_ready;
        acc1 = req1_valid & req1_ready;
        if (fifo_wr_en) wq.push_back(fifo_din);
        @(posedge wr_clk); #1;
        if (acc0) void'(q0.pop_front());
        if (acc1) void'(q1.pop_front());
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge wr_clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge wr_clk);
        @(negedge wr_clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b exp 00", grant); end
        checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b exp 0", fifo_wr_en); end
        checks++; if ({frame_cnt0, frame_cnt1} !== {2*CW{1'b0}}) begin errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", frame_cnt0, frame_cnt1); end
        checks++; if ({proto_err, len_err, ovf_err} !== 3'b000) begin errors++; $display("FAIL reset_errs got %b exp 000", {proto_err, len_err, ovf_err}); end
        @(posedge wr_clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_arbitration();
        logic [1:0]    exp_g [12] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10,
                                      2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
        logic [DW-1:0] exp_w [8];
        exp_w = '{mk(1'b0, 1'b1, 34'h0B0), mk(1'b1, 1'b0, 34'h0B1),
                  mk(1'b0, 1'b1, 34'h0D0), mk(1'b1, 1'b0, 34'h0D1),
                  mk(1'b0, 1'b1, 34'h0C0), mk(1'b1, 1'b0, 34'h0C1),
                  mk(1'b0, 1'b1, 34'h0E0), mk(1'b1, 1'b0, 34'h0E1)};
        wq.delete();
        q0.push_back(exp_w[0]); q0.push_back(exp_w[1]); q0.push_back(exp_w[4]); q0.push_back(exp_w[5]);
        q1.push_back(exp_w[2]); q1.push_back(exp_w[3]); q1.push_back(exp_w[6]); q1.push_back(exp_w[7]);
        for (int i = 0; i < 12; i++) begin
            cycle();
            checks++;
            if (s_grant !== exp_g[i]) begin errors++; $display("FAIL arb_grant[%0d] got %b exp %b", i, s_grant, exp_g[i]); end
        end
        cycle();
        checks++; if (wq.size() !== 8) begin errors++; $display("FAIL arb_nwords got %0d exp 8", wq.size()); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (wq[i] !== exp_w[i]) begin errors++; $display("FAIL arb_word[%0d] got %h exp %h", i, wq[i], exp_w[i]); end
        end
        checks++; if (frame_cnt0 !== 16'd2 || frame_cnt1 !== 16'd2) begin errors++; $display("FAIL arb_cnt got %0d/%0d exp 2/2", frame_cnt0, frame_cnt1); end
    endtask

    task automatic test_single_frame();
        logic [DW-1:0] a [3];
        a = '{mk(1'b0, 1'b1, 34'h2_0000_00A0), mk(1'b0, 1'b0, 34'h1_5555_00A1), mk(1'b1, 1'b0, 34'h3_FFFF_00A2)};
        wq.delete();
        for (int i = 0; i < 3; i++) q0.push_back(a[i]);
        cycle();
        checks++; if (s_grant !== 2'b00 || s_wr_en !== 1'b0) begin errors++; $display("FAIL single_arb got grant %b wr %b exp 00 0", s_grant, s_wr_en); end
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (s_grant !== 2'b01 || s_wr_en !== 1'b1 || s_din !== a[i]) begin
                errors++; $display("FAIL single_word[%0d] got grant %b wr %b din %h exp 01 1 %h", i, s_grant, s_wr_en, s_din, a[i]);
            end
        end
        cycle();
        checks++; if (s_grant !== 2'b00) begin errors++; $display("FAIL single_release got %b exp 00", s_grant); end
        checks++; if (frame_cnt0 !== 16'd3) begin errors++; $display("FAIL single_cnt got %0d exp 3", frame_cnt0); end
    endtask

    task automatic test_full_stall();
        logic [DW-1:0] f [4];
        int stalls;
        f = '{mk(1'b0, 1'b1, 34'h0F0), mk(1'b0, 1'b0, 34'h0F1), mk(1'b0, 1'b0, 34'h0F2), mk(1'b1, 1'b0, 34'h0F3)};
        wq.delete();
        stalls = 0;
        for (int i = 0; i < 4; i++) q0.push_back(f[i]);
        cycle();
        cycle();
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (s_rdy0 == 1'b0 && s_wr_en == 1'b0 && s_grant == 2'b01) stalls++;
        end
        fifo_full = 1'b0;
        checks++; if (stalls !== 5) begin errors++; $display("FAIL full_stall_cycles got %0d exp 5", stalls); end
        repeat (4) cycle();
        checks++; if (wq.size() !== 4) begin errors++; $display("FAIL full_nwords got %0d exp 4", wq.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wq[i] !== f[i]) begin errors++; $display("FAIL full_word[%0d] got %h exp %h", i, wq[i], f[i]); end
        end
        checks++; if (frame_cnt0 !== 16'd4 || len_err !== 1'b0 || proto_err !== 1'b0) begin
            errors++; $display("FAIL full_end got cnt %0d len %b proto %b exp 4 0 0", frame_cnt0, len_err, proto_err);
        end
    endtask

    task automatic test_len_err();
        wq.delete();
        for (int i = 0; i < 6; i++) q1.push_back(mk(i == 5, i == 0, 34'(32'h100 + i)));
        repeat (5) cycle();
        checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL len_early got %b exp 0", len_err); end
        cycle();
        checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL len_fifth got %b exp 1", len_err); end
        repeat (2) cycle();
        checks++; if (wq.size() !== 6) begin errors++; $display("FAIL len_nwords got %0d exp 6", wq.size()); end
        checks++; if (frame_cnt1 !== 16'd3 || proto_err !== 1'b0) begin errors++; $display("FAIL len_cnt got %0d proto %b exp 3 0", frame_cnt1, proto_err); end
    endtask

    task automatic test_proto_stray();
        wq.delete();
        q0.push_back(mk(1'b0, 1'b0, 34'h0A5));
        q1.push_back(mk(1'b0, 1'b0, 34'h05A));
        cycle();
        checks++; if (s_rdy0 !== 1'b1 || s_rdy1 !== 1'b1 || s_wr_en !== 1'b0) begin
            errors++; $display("FAIL stray_drain got rdy %b%b wr %b exp 11 0", s_rdy1, s_rdy0, s_wr_en);
        end
        checks++; if (proto_err !== 1'b1 || q0.size() != 0 || q1.size() != 0) begin
            errors++; $display("FAIL stray_flag got proto %b left %0d/%0d exp 1 0/0", proto_err, q0.size(), q1.size());
        end
    endtask

    task automatic test_proto_midframe();
        logic [DW-1:0] b;
        b = mk(1'b0, 1'b1, 34'h0B1);
        do_reset();
        wq.delete();
        q0.push_back(mk(1'b0, 1'b1, 34'h0B0)); q0.push_back(b); q0.push_back(mk(1'b1, 1'b0, 34'h0B2));
        repeat (2) cycle();
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL mid_first got %b exp 0", proto_err); end
        cycle();
        checks++; if (proto_err !== 1'b1 || s_wr_en !== 1'b1 || s_din !== b) begin
            errors++; $display("FAIL mid_sop got proto %b wr %b din %h exp 1 1 %h", proto_err, s_wr_en, s_din, b);
        end
        repeat (2) cycle();
        checks++; if (frame_cnt0 !== 16'd1 || wq.size() !== 3) begin errors++; $display("FAIL mid_end got cnt %0d words %0d exp 1 3", frame_cnt0, wq.size()); end
    endtask

    task automatic test_overflow();
        checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_before got %b exp 0", ovf_err); end
        fifo_overflow = 1'b1;
        cycle();
        fifo_overflow = 1'b0;
        cycle();
        checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", ovf_err); end
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 5; i++) q0.push_back(mk(i == 4, i == 0, 34'(32'h300 + i)));
        repeat (3) cycle();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rmid_pre got %b exp 01", grant); end
        #2;
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        checks++; if (grant !== 2'b00 || fifo_wr_en !== 1'b0) begin errors++; $display("FAIL rmid_grant got %b wr %b exp 00 0", grant, fifo_wr_en); end
        checks++; if (frame_cnt0 !== 16'd0 || frame_cnt1 !== 16'd0) begin errors++; $display("FAIL rmid_cnt got %0d/%0d exp 0/0", frame_cnt0, frame_cnt1); end
        checks++; if ({proto_err, len_err, ovf_err} !== 3'b000) begin errors++; $display("FAIL rmid_errs got %b exp 000", {proto_err, len_err, ovf_err}); end
        q0.delete();
        @(negedge wr_clk); #1;
        rst = 1'b0;
        @(posedge wr_clk); #1;
        wq.delete();
        q0.push_back(mk(1'b0, 1'b1, 34'h0C0)); q0.push_back(mk(1'b1, 1'b0, 34'h0C1));
        cycle();
        checks++; if (s_grant !== 2'b00) begin errors++; $display("FAIL rmid_arb got %b exp 00", s_grant); end
        cycle();
        checks++; if (s_grant !== 2'b01 || s_din !== mk(1'b0, 1'b1, 34'h0C0)) begin errors++; $display("FAIL rmid_sop got %b %h", s_grant, s_din); end
        repeat (2) cycle();
        checks++; if (frame_cnt0 !== 16'd1 || proto_err !== 1'b0) begin errors++; $display("FAIL rmid_after got cnt %0d proto %b exp 1 0", frame_cnt0, proto_err); end
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_single_frame();
        test_full_stall();
        test_len_err();
        test_proto_stray();
        test_proto_midframe();
        test_overflow();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
